// File: rtl/cnt_cmd_ctrl_if.sv
// Bundles the button inputs, the overflow loop-back and the counter-control
// outputs of the command stage. The master side drives the buttons and the
// overflow flag. The slave side is the command stage itself.
interface cnt_cmd_ctrl_if;
    logic       btn_start;
    logic       btn_stop;
    logic       btn_dir;
    logic       overflow;
    logic       act;
    logic       up_down;
    logic       cnt_clr;
    logic       halted;
    logic [2:0] state_dbg;

    modport master (
        output btn_start,
        output btn_stop,
        output btn_dir,
        output overflow,
        input  act,
        input  up_down,
        input  cnt_clr,
        input  halted,
        input  state_dbg
    );

    modport slave (
        input  btn_start,
        input  btn_stop,
        input  btn_dir,
        input  overflow,
        output act,
        output up_down,
        output cnt_clr,
        output halted,
        output state_dbg
    );
endinterface

// File: rtl/cnt_cmd_ctrl.sv
// Command front-end for the up/down counter.
// Each raw pushbutton goes through a synchroniser, a debouncer and a
// rising-edge pulse register. The resulting one-cycle press pulses drive a
// Moore FSM. The FSM enables the counter, sets its direction, and recovers
// from overflow by pulsing the counter's clear input.
module cnt_cmd_ctrl #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CLR_PULSE       = 2
) (
    input  logic          clk,
    input  logic          reset,
    cnt_cmd_ctrl_if.slave bus
);

    localparam int unsigned NB = 3;  // buttons: 0=start, 1=stop, 2=dir
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned CW = $clog2(CLR_PULSE + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_PULSE - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN_UP   = 3'd1,
        S_RUN_DN   = 3'd2,
        S_HALT_OVF = 3'd3,
        S_CLEAR    = 3'd4
    } state_t;

    logic [NB-1:0] raw_btn;
    logic [NB-1:0] press;

    assign raw_btn = {bus.btn_dir, bus.btn_stop, bus.btn_start};

    // Per-button conditioning chain: synchroniser -> debouncer -> press pulse.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_btn
            logic [SYNC_STAGES-1:0] sync_q;
            logic [DW-1:0]          db_cnt_q;
            logic                   level_q;
            logic                   level_prev_q;
            logic                   pulse_q;

            // Shift the raw button into the synchroniser chain. The MSB is the
            // metastability-safe sample.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], raw_btn[gi]};
                end
            end

            // Accept a new level only after DEBOUNCE_CYCLES consecutive synced
            // samples disagree with it. Any agreeing sample restarts the count.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    db_cnt_q <= '0;
                    level_q  <= 1'b0;
                end else if (sync_q[SYNC_STAGES-1] == level_q) begin
                    db_cnt_q <= '0;
                end else if (db_cnt_q == DB_LAST) begin
                    level_q  <= sync_q[SYNC_STAGES-1];
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end

            // One registered pulse per debounced rising edge. A held button gives
            // a single pulse, and a release gives none.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    level_prev_q <= 1'b0;
                    pulse_q      <= 1'b0;
                end else begin
                    level_prev_q <= level_q;
                    pulse_q      <= level_q & ~level_prev_q;
                end
            end

            assign press[gi] = pulse_q;
        end
    endgenerate

    logic start_p;
    logic stop_p;
    logic dir_p;

    assign start_p = press[0];
    assign stop_p  = press[1];
    assign dir_p   = press[2];

    state_t        state_q;
    state_t        state_d;
    logic          dir_q;
    logic          dir_d;
    logic [CW-1:0] clr_cnt_q;
    logic [CW-1:0] clr_cnt_d;
    logic          act_q;
    logic          up_down_q;
    logic          cnt_clr_q;
    logic          halted_q;

    // Next-state logic. Priority within a cycle is overflow > stop > dir > start.
    // A dir pulse toggles the direction in IDLE and in both RUN states, even
    // when a higher-priority event wins the state transition in that cycle.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (dir_p) begin
                    dir_d = ~dir_q;
                end
                // Start uses the direction after any same-cycle toggle.
                if (start_p) begin
                    state_d = dir_d ? S_RUN_UP : S_RUN_DN;
                end
            end
            S_RUN_UP: begin
                if (dir_p) begin
                    dir_d = ~dir_q;
                end
                if (bus.overflow) begin
                    state_d = S_HALT_OVF;
                end else if (stop_p) begin
                    state_d = S_IDLE;
                end else if (dir_p) begin
                    state_d = S_RUN_DN;
                end
            end
            S_RUN_DN: begin
                if (dir_p) begin
                    dir_d = ~dir_q;
                end
                if (bus.overflow) begin
                    state_d = S_HALT_OVF;
                end else if (stop_p) begin
                    state_d = S_IDLE;
                end else if (dir_p) begin
                    state_d = S_RUN_UP;
                end
            end
            S_HALT_OVF: begin
                // Only stop leaves the halt. The clear timer reloads on entry to CLEAR.
                if (stop_p) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, direction and the outputs, registered together from the next
    // state so the outputs never see a combinational path from the inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            dir_q     <= 1'b1;
            clr_cnt_q <= '0;
            act_q     <= 1'b0;
            up_down_q <= 1'b1;
            cnt_clr_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            clr_cnt_q <= clr_cnt_d;
            act_q     <= (state_d == S_RUN_UP) || (state_d == S_RUN_DN);
            up_down_q <= dir_d;
            cnt_clr_q <= (state_d == S_CLEAR);
            halted_q  <= (state_d == S_HALT_OVF);
        end
    end

    assign bus.act       = act_q;
    assign bus.up_down   = up_down_q;
    assign bus.cnt_clr   = cnt_clr_q;
    assign bus.halted    = halted_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_cnt_cmd_ctrl.sv
// Directed bench for cnt_cmd_ctrl with SYNC_STAGES=2, DEBOUNCE_CYCLES=4 and
// CLR_PULSE=2. A held button therefore reaches the outputs 8 edges after the
// first sampling edge.
module tb_cnt_cmd_ctrl;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    cnt_cmd_ctrl_if bus ();

    cnt_cmd_ctrl #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CLR_PULSE      (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0:       bus.btn_start = v;
            1:       bus.btn_stop  = v;
            default: bus.btn_dir   = v;
        endcase
    endtask

    // Hold a button for 'hold' edges starting at the current negedge, then release it.
    task automatic press(input int which, input int hold);
        set_btn(which, 1'b1);
        cyc(hold);
        set_btn(which, 1'b0);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        bus.btn_start = 1'b0;
        bus.btn_stop  = 1'b0;
        bus.btn_dir   = 1'b0;
        bus.overflow  = 1'b0;
        cyc(3);
        chk("rst_act", bus.act, 3'd0);
        chk("rst_up_down", bus.up_down, 3'd1);
        chk("rst_cnt_clr", bus.cnt_clr, 3'd0);
        chk("rst_halted", bus.halted, 3'd0);
        chk("rst_state", bus.state_dbg, 3'd0);
        reset = 1'b0;
        cyc(2);

        // 1: start held 10 cycles; the outputs change on edge 8.
        bus.btn_start = 1'b1;
        cyc(7);
        chk("t1_edge7_state", bus.state_dbg, 3'd0);
        chk("t1_edge7_act", bus.act, 3'd0);
        cyc(1);
        chk("t1_edge8_state", bus.state_dbg, 3'd1);
        chk("t1_edge8_act", bus.act, 3'd1);
        chk("t1_edge8_up_down", bus.up_down, 3'd1);
        cyc(2);
        bus.btn_start = 1'b0;
        cyc(12);
        chk("t1_after_release_act", bus.act, 3'd1);
        chk("t1_after_release_state", bus.state_dbg, 3'd1);

        // 2: a 3-cycle stop glitch is rejected, then a held stop returns to IDLE.
        press(1, 3);
        cyc(12);
        chk("t2_glitch_state", bus.state_dbg, 3'd1);
        chk("t2_glitch_act", bus.act, 3'd1);
        press(1, 6);
        cyc(1);
        chk("t2_edge7_state", bus.state_dbg, 3'd1);
        cyc(1);
        chk("t2_edge8_state", bus.state_dbg, 3'd0);
        chk("t2_edge8_act", bus.act, 3'd0);
        cyc(10);

        // 3: back to RUN_UP, then a dir press switches to RUN_DN.
        press(0, 6);
        cyc(2);
        chk("t3_run_up_state", bus.state_dbg, 3'd1);
        cyc(10);
        press(2, 6);
        cyc(1);
        chk("t3_edge7_state", bus.state_dbg, 3'd1);
        chk("t3_edge7_act", bus.act, 3'd1);
        chk("t3_edge7_up_down", bus.up_down, 3'd1);
        cyc(1);
        chk("t3_edge8_state", bus.state_dbg, 3'd2);
        chk("t3_edge8_act", bus.act, 3'd1);
        chk("t3_edge8_up_down", bus.up_down, 3'd0);
        cyc(10);

        // 4: overflow in RUN_DN halts. Start is ignored, and stop clears for 2 cycles.
        bus.overflow = 1'b1;
        cyc(1);
        bus.overflow = 1'b0;
        chk("t4_ovf_state", bus.state_dbg, 3'd3);
        chk("t4_ovf_act", bus.act, 3'd0);
        chk("t4_ovf_halted", bus.halted, 3'd1);
        press(0, 6);
        cyc(12);
        chk("t4_start_ignored_state", bus.state_dbg, 3'd3);
        chk("t4_start_ignored_halted", bus.halted, 3'd1);
        press(1, 6);
        cyc(1);
        chk("t4_edge7_cnt_clr", bus.cnt_clr, 3'd0);
        cyc(1);
        chk("t4_clear1_state", bus.state_dbg, 3'd4);
        chk("t4_clear1_cnt_clr", bus.cnt_clr, 3'd1);
        chk("t4_clear1_halted", bus.halted, 3'd0);
        cyc(1);
        chk("t4_clear2_cnt_clr", bus.cnt_clr, 3'd1);
        cyc(1);
        chk("t4_done_cnt_clr", bus.cnt_clr, 3'd0);
        chk("t4_done_state", bus.state_dbg, 3'd0);
        chk("t4_done_up_down", bus.up_down, 3'd0);
        cyc(10);

        // 5: in IDLE, dir toggles back to up; start gives RUN_UP. Overflow and the
        //    stop pulse arrive together, and HALT_OVF wins.
        press(2, 6);
        cyc(2);
        chk("t5_idle_dir_up_down", bus.up_down, 3'd1);
        chk("t5_idle_dir_state", bus.state_dbg, 3'd0);
        cyc(10);
        press(0, 6);
        cyc(2);
        chk("t5_run_up_state", bus.state_dbg, 3'd1);
        cyc(10);
        press(1, 6);
        cyc(1);
        bus.overflow = 1'b1;
        cyc(1);
        bus.overflow = 1'b0;
        chk("t5_ovf_stop_state", bus.state_dbg, 3'd3);
        chk("t5_ovf_stop_halted", bus.halted, 3'd1);
        cyc(10);
        press(1, 6);
        cyc(5);
        chk("t5_recovered_state", bus.state_dbg, 3'd0);
        cyc(10);

        // 6: move to RUN_DN and HALT_OVF, then reset asynchronously in CLEAR.
        press(2, 6);
        cyc(12);
        chk("t6_dir_down", bus.up_down, 3'd0);
        press(0, 6);
        cyc(2);
        chk("t6_run_dn_state", bus.state_dbg, 3'd2);
        cyc(10);
        bus.overflow = 1'b1;
        cyc(1);
        bus.overflow = 1'b0;
        chk("t6_halt_state", bus.state_dbg, 3'd3);
        press(1, 6);
        cyc(2);
        chk("t6_clear_state", bus.state_dbg, 3'd4);
        chk("t6_clear_cnt_clr", bus.cnt_clr, 3'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_cnt_clr", bus.cnt_clr, 3'd0);
        chk("t6_async_act", bus.act, 3'd0);
        chk("t6_async_halted", bus.halted, 3'd0);
        chk("t6_async_up_down", bus.up_down, 3'd1);
        chk("t6_async_state", bus.state_dbg, 3'd0);
        @(negedge clk);
        cyc(1);
        reset = 1'b0;
        cyc(2);
        press(0, 6);
        cyc(1);
        chk("t6_restart_edge7_state", bus.state_dbg, 3'd0);
        cyc(1);
        chk("t6_restart_state", bus.state_dbg, 3'd1);
        chk("t6_restart_act", bus.act, 3'd1);
        chk("t6_restart_up_down", bus.up_down, 3'd1);
        chk("t6_restart_cnt_clr", bus.cnt_clr, 3'd0);
        cyc(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
